// File: rtl/rv32_mem_pkg.sv
// Shared types and default widths for the single-port memory arbiter slice.
package rv32_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    D_RD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts data grants that bypass a waiting fetch; flags when fetch must win the next contended cycle.
// Latency: flag is registered state, visible the cycle after the count reaches STARVE_MAX.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_starved
);

  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starved = (r_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory: grant is combinational, read data returns one cycle later.
// Data has priority; with ARB_STARVE_GUARD_EN defined, fetch wins a contended cycle after STARVE_MAX consecutive bypasses.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       w_fetch_first;
  logic       w_if_gnt;
  logic       w_d_gnt;

`ifdef ARB_STARVE_GUARD_EN
  logic w_starved;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_d_gnt & i_if_req),
    .i_clr    (w_if_gnt | ~i_if_req),
    .o_starved(w_starved)
  );

  assign w_fetch_first = w_starved;
`else
  // Strict data priority; STARVE_MAX only matters when the guard is built in.
  assign w_fetch_first = (STARVE_MAX < 0);
`endif

  // Requests seen while reset is high are never granted.
  assign w_d_gnt  = ~reset & i_d_req & ~(i_if_req & w_fetch_first);
  assign w_if_gnt = ~reset & i_if_req & ~w_d_gnt;

  assign o_if_gnt    = w_if_gnt;
  assign o_d_gnt     = w_d_gnt;
  assign o_mem_en    = w_if_gnt | w_d_gnt;
  assign o_mem_we    = w_d_gnt & i_d_we;
  assign o_mem_addr  = w_d_gnt ? i_d_addr : (w_if_gnt ? i_if_addr : '0);
  assign o_mem_wdata = (w_d_gnt & i_d_we) ? i_d_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = IDLE;
    if (w_if_gnt) begin
      w_next = IF_RD;
    end else if (w_d_gnt && !i_d_we) begin
      w_next = D_RD;
    end
  end

  // The state names whose read is returning this cycle; reset masks it immediately.
  always_comb begin
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_d_rvalid  = 1'b0;
    o_d_rdata   = '0;
    if (!reset) begin
      case (r_state)
        IF_RD: begin
          o_if_rvalid = 1'b1;
          o_if_rdata  = i_mem_rdata;
        end
        D_RD: begin
          o_d_rvalid = 1'b1;
          o_d_rdata  = i_mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random stimulus for mem_port_arbiter against a per-cycle reference model and a behavioural memory.
module tb_mem_port_arbiter;

  localparam int AW         = 10;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_d_req;
  logic          i_d_we;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic          o_d_gnt;
  logic          o_d_rvalid;
  logic [DW-1:0] o_d_rdata;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  // Behavioural single-port memory with registered read data.
  logic [DW-1:0] emu_mem [DEPTH];
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) emu_mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata <= emu_mem[o_mem_addr];
    end
  end

  // Reference model state: expected memory image, outstanding response, fairness count.
  logic [DW-1:0] model_mem [DEPTH];
  int            m_pend;      // 0 none, 1 fetch, 2 data
  logic [DW-1:0] m_pdat;
  int            m_cnt;
  bit            m_if_gnt, m_d_gnt;
  int            n_cmp = 0;
  int            n_err = 0;
  int            rv_seen;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hA5000000 ^ (32'(i) * 32'h9E3779B1));
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ifr, input logic [AW-1:0] ifa,
                      input bit dr, input bit dwe, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd);
    bit fire, ed, ei, eiv, edv;
    reset = rst; i_if_req = ifr; i_if_addr = ifa;
    i_d_req = dr; i_d_we = dwe; i_d_addr = da; i_d_wdata = dwd;
`ifdef ARB_STARVE_GUARD_EN
    fire = (m_cnt == STARVE_MAX);
`else
    fire = 1'b0;
`endif
    ed  = !rst && dr && !(ifr && fire);
    ei  = !rst && ifr && !ed;
    eiv = !rst && (m_pend == 1);
    edv = !rst && (m_pend == 2);
    @(negedge clk);
    chk("if_gnt", 32'(o_if_gnt), 32'(ei));
    chk("d_gnt", 32'(o_d_gnt), 32'(ed));
    chk("mem_en", 32'(o_mem_en), 32'(ei || ed));
    chk("mem_we", 32'(o_mem_we), 32'(ed && dwe));
    if (ei) chk("mem_addr_if", 32'(o_mem_addr), 32'(ifa));
    if (ed) chk("mem_addr_d", 32'(o_mem_addr), 32'(da));
    if (ed && dwe) chk("mem_wdata", o_mem_wdata, dwd);
    chk("if_rvalid", 32'(o_if_rvalid), 32'(eiv));
    chk("if_rdata", o_if_rdata, eiv ? m_pdat : '0);
    chk("d_rvalid", 32'(o_d_rvalid), 32'(edv));
    chk("d_rdata", o_d_rdata, edv ? m_pdat : '0);
    rv_seen += int'(o_if_rvalid) + int'(o_d_rvalid);
    if (rst) begin
      m_pend = 0;
      m_cnt  = 0;
    end else begin
      if (ei) begin
        m_pend = 1; m_pdat = model_mem[ifa];
      end else if (ed && !dwe) begin
        m_pend = 2; m_pdat = model_mem[da];
      end else begin
        m_pend = 0;
      end
      if (ed && dwe) model_mem[da] = dwd;
      if (ei || !ifr) m_cnt = 0;
      else if (ed) m_cnt = m_cnt + 1;
    end
    m_if_gnt = ei;
    m_d_gnt  = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    bit            ifp, dp, dwe_r;
    logic [AW-1:0] ifa_r, da_r;
    logic [DW-1:0] dwd_r;
    for (int i = 0; i < DEPTH; i++) begin
      emu_mem[i]   = init_word(i);
      model_mem[i] = init_word(i);
    end
    m_pend = 0; m_cnt = 0; m_pdat = '0; rv_seen = 0;

    // Requests held through reset must not be granted.
    step(1, 1, 10'h005, 1, 0, 10'h006, '0);
    step(1, 1, 10'h005, 1, 1, 10'h006, 32'h0BAD0BAD);

    // Fetch only, address 0x010.
    step(0, 1, 10'h010, 0, 0, '0, '0);
    idle();

    // Contention: data read wins, fetch follows once data drops.
    step(0, 1, 10'h040, 1, 0, 10'h020, '0);
    step(0, 1, 10'h040, 0, 0, '0, '0);
    idle();

    // Write, then read it back.
    step(0, 0, '0, 1, 1, 10'h030, 32'h12345678);
    idle();
    step(0, 0, '0, 1, 0, 10'h030, '0);
    idle();

    // Both held six cycles: fairness boundary.
    for (int c = 0; c < 6; c++) step(0, 1, 10'h011, 1, 0, 10'h022, '0);
    idle();

    // Reset right after a fetch grant kills its response.
    step(0, 1, 10'h012, 0, 0, '0, '0);
    step(1, 0, '0, 0, 0, '0, '0);
    idle();

    // Alternating fetch/data reads, eight cycles.
    rv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) step(0, 1, 10'(16 + c), 0, 0, '0, '0);
      else            step(0, 0, '0, 1, 0, 10'(48 + c), '0);
    end
    idle();
    chk("alt_resp_count", 32'(rv_seen), 32'd8);

    // Random traffic with held requests and occasional reset.
    ifp = 0; dp = 0; dwe_r = 0; ifa_r = '0; da_r = '0; dwd_r = '0;
    for (int c = 0; c < 400; c++) begin
      if (!ifp && $urandom_range(0, 3) != 0) begin
        ifp = 1; ifa_r = 10'($urandom_range(0, 63));
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; dwe_r = ($urandom_range(0, 2) == 0);
        da_r = 10'($urandom_range(0, 63)); dwd_r = $urandom;
      end
      step($urandom_range(0, 49) == 0, ifp, ifa_r, dp, dwe_r, da_r, dwd_r);
      if (m_if_gnt) ifp = 0;
      if (m_d_gnt)  dp = 0;
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the shared memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while fetch waits.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_req  input  1  fetch read request; held with if_addr stable until if_gnt.
REQ-007 if_addr  input  ADDR_W  fetch word address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  if_rdata valid; one cycle after if_gnt.
REQ-010 if_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  data access request; held with d_we/d_addr/d_wdata stable until d_gnt.
REQ-012 d_we  input  1  1 = write, 0 = read.
REQ-013 d_addr  input  ADDR_W  data word address.
REQ-014 d_wdata  input  DATA_W  write data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  d_rdata valid; one cycle after a read d_gnt, never for writes.
REQ-017 d_rdata  output  DATA_W  data read data.
REQ-018 mem_en, mem_we  output  1 each  single-port memory enable/write-enable.
REQ-019 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory address/write data.
REQ-020 mem_rdata  input  DATA_W  memory read data, registered, valid one cycle after mem_en with mem_we=0.

Function
REQ-021 SHALL issue at most one memory access per cycle; grant decision combinational from current requests and registered state.
REQ-022 Default priority: data over fetch (memory-stage access must not stall behind fetch).
REQ-023 Grant SHALL drive mem_en=1 and mem_we/mem_addr/mem_wdata from the granted port in the same cycle; no grant -> mem_en=0, mem_we=0.
REQ-024 FSM states: IDLE, IF_RD, D_RD; next state IF_RD on fetch grant, D_RD on data read grant, IDLE on data write or no grant.
REQ-025 In IF_RD: if_rvalid=1, if_rdata=mem_rdata; in D_RD: d_rvalid=1, d_rdata=mem_rdata; otherwise rvalid=0, rdata=0.
REQ-026 Back-to-back grants SHALL be allowed: a new grant in any state, response pipelined one cycle behind (throughput 1 access/cycle).
REQ-027 Both rvalid outputs SHALL never be high in the same cycle.
REQ-028 Write grant SHALL complete in the grant cycle; no response.
REQ-029 Simultaneous if_req and d_req: d_gnt=1, if_gnt=0 (subject to REQ-034).

Reset
REQ-030 On reset: state IDLE, starvation counter 0; if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we = 0; rdata outputs 0.
REQ-031 Reset asserted while a read is in flight SHALL suppress its rvalid in the following cycle.
REQ-032 Requests present during reset SHALL not be granted.

Configuration
REQ-033 Macro ARB_STARVE_GUARD_EN SHALL enable the fetch fairness guard.
REQ-034 With it: counter increments on each data grant while if_req=1 and if_gnt=0, clears on fetch grant or if_req=0; when counter equals STARVE_MAX, fetch wins the next contended cycle.
REQ-035 Without it: strict data priority, no counter logic; fetch may starve indefinitely.

Structure
REQ-036 Package rv32_mem_pkg SHALL hold the state enum (IDLE/IF_RD/D_RD) and default ADDR_W/DATA_W constants.
REQ-037 Starvation counter SHALL be sub-module arb_starve_ctr, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x010, mem_rdata=0xDEADBEEF next cycle -> if_gnt same cycle, if_rvalid=1 with if_rdata=0xDEADBEEF one cycle later.
REQ-039 Contention: if_req=1 and d_req=1 (read 0x020) same cycle -> d_gnt=1, if_gnt=0; next cycle d_rvalid=1, fetch granted if d_req dropped.
REQ-040 Data write 0x030 <= 0x12345678 -> mem_en=1, mem_we=1, mem_wdata=0x12345678 in grant cycle; no d_rvalid afterward.
REQ-041 Guard on, STARVE_MAX=4, both requests held 6 cycles -> d_gnt cycles 1-4, if_gnt cycle 5; guard off -> d_gnt all 6 cycles.
REQ-042 Reset asserted cycle after a fetch read grant -> if_rvalid=0, all outputs 0 the cycle after reset.
REQ-043 Alternating fetch/data reads every cycle for 8 cycles -> 8 responses, exactly one rvalid per cycle, data matches address order.
